// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-2 schedule constants, small-sigma amounts and scheduler FSM state type
package sha2_pkg;
  localparam int SHA256_W = 32;
  localparam int SHA512_W = 64;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA512_ROUNDS = 80;
  // [sel][i]: sel 0 = sigma0, 1 = sigma1; i 0/1 = rotate amounts, 2 = shift amount
  localparam int SIG256 [2][3] = '{'{7, 18, 3}, '{17, 19, 10}};
  localparam int SIG512 [2][3] = '{'{1, 8, 7}, '{19, 61, 6}};
  typedef enum logic {IDLE, RUN} state_e;
  function automatic int sig_amt(input int word_w, input int sel, input int i);
    return word_w == SHA256_W ? SIG256[sel][i] : SIG512[sel][i];
  endfunction
  function automatic int rounds_for(input int word_w);
    return word_w == SHA256_W ? SHA256_ROUNDS : SHA512_ROUNDS;
  endfunction
endpackage

// File: rtl/sha2_small_sigma.sv
// sha2_small_sigma: combinational SHA-2 small sigma (SEL 0 = sigma0, 1 = sigma1)
// x_i: input word; y_o: rotr(a) ^ rotr(b) ^ shr(c) for the selected mode
module sha2_small_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SEL = 0
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);
  localparam int RA = sig_amt(WORD_W, SEL, 0);
  localparam int RB = sig_amt(WORD_W, SEL, 1);
  localparam int SH = sig_amt(WORD_W, SEL, 2);
  assign y_o = (x_i >> RA | x_i << (WORD_W - RA)) ^ (x_i >> RB | x_i << (WORD_W - RB)) ^ (x_i >> SH);
endmodule

// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-256/512 message scheduler streaming W0..W(ROUNDS-1) per accepted block
// blk_i/blk_v_i/blk_ready_o: 16-word block in (word 0 in MSBs); flush_i: abort block in flight
// wt_o/t_o/last_o/wt_v_o/wt_ready_i: schedule word stream out with index and last flag
module sha2_msg_sched
  import sha2_pkg::*;
#(
  parameter int WORD_W = SHA256_W,
  parameter int ROUNDS = rounds_for(WORD_W),
  parameter int IDX_W = $clog2(ROUNDS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [16*WORD_W-1:0] blk_i,
  input  logic                 blk_v_i,
  output logic                 blk_ready_o,
  input  logic                 flush_i,
  output logic [WORD_W-1:0]    wt_o,
  output logic [IDX_W-1:0]     t_o,
  output logic                 last_o,
  output logic                 wt_v_o,
  input  logic                 wt_ready_i
);
  if (WORD_W != SHA256_W && WORD_W != SHA512_W) begin : g_bad_width
    $error("sha2_msg_sched: WORD_W must be 32 or 64");
  end
  state_e state_q, state_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [IDX_W-1:0] t_q, t_d;
  logic [WORD_W-1:0] s0, s1, w_new;
  logic run, hs, acc;
  sha2_small_sigma #(.WORD_W(WORD_W), .SEL(0)) u_s0 (.x_i(win_q[1]), .y_o(s0));
  sha2_small_sigma #(.WORD_W(WORD_W), .SEL(1)) u_s1 (.x_i(win_q[14]), .y_o(s1));
  assign w_new = s1 + win_q[9] + s0 + win_q[0];
  assign run = state_q == RUN;
  assign wt_o = win_q[0];
  assign t_o = t_q;
  assign last_o = t_q == IDX_W'(ROUNDS - 1);
  assign wt_v_o = run;
  // flush masks ready so a block is never accepted in a flush cycle
  assign blk_ready_o = !flush_i && (!run || (wt_ready_i && last_o));
  assign acc = blk_v_i && blk_ready_o;
  assign hs = run && wt_ready_i && !flush_i;
  always_comb begin
    state_d = flush_i ? IDLE : acc ? RUN : (hs && last_o) ? IDLE : state_q;
    t_d = (flush_i || acc || (hs && last_o)) ? '0 : hs ? t_q + IDX_W'(1) : t_q;
    for (int k = 0; k < 15; k++)
      win_d[k] = acc ? blk_i[(15-k)*WORD_W +: WORD_W] : hs ? win_q[k+1] : win_q[k];
    win_d[15] = acc ? blk_i[WORD_W-1:0] : hs ? w_new : win_q[15];
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      t_q <= '0;
      win_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      win_q <= win_d;
    end
endmodule

// File: tb/tb_sha2_msg_sched.sv
// tb_sha2_msg_sched: directed bench for the SHA-256 and SHA-512 message scheduler
module tb_sha2_msg_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [511:0] blk32 = '0;
  logic bv32 = 1'b0, fl32 = 1'b0, wr32 = 1'b0;
  logic br32, last32, wv32;
  logic [31:0] wt32;
  logic [5:0] t32;
  logic [1023:0] blk64 = '0;
  logic bv64 = 1'b0, fl64 = 1'b0, wr64 = 1'b0;
  logic br64, last64, wv64;
  logic [63:0] wt64;
  logic [6:0] t64;
  int total = 0, bad = 0;
  logic [31:0] m32 [2][64];
  logic [63:0] m64 [80];
  logic [511:0] abc32, rnd32;
  logic [1023:0] abc64;

  sha2_msg_sched #(.WORD_W(32)) dut32 (
    .clk_i(clk), .reset_i(rst), .blk_i(blk32), .blk_v_i(bv32), .blk_ready_o(br32),
    .flush_i(fl32), .wt_o(wt32), .t_o(t32), .last_o(last32), .wt_v_o(wv32), .wt_ready_i(wr32));
  sha2_msg_sched #(.WORD_W(64)) dut64 (
    .clk_i(clk), .reset_i(rst), .blk_i(blk64), .blk_v_i(bv64), .blk_ready_o(br64),
    .flush_i(fl64), .wt_o(wt64), .t_o(t64), .last_o(last64), .wt_v_o(wv64), .wt_ready_i(wr64));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    return 32'({x, x} >> n);
  endfunction
  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    return 64'({x, x} >> n);
  endfunction

  task automatic sched32(input logic [511:0] b, input int s);
    for (int t = 0; t < 64; t++)
      if (t < 16) m32[s][t] = b[511-32*t -: 32];
      else m32[s][t] = (rr32(m32[s][t-2], 17) ^ rr32(m32[s][t-2], 19) ^ (m32[s][t-2] >> 10))
                     + m32[s][t-7]
                     + (rr32(m32[s][t-15], 7) ^ rr32(m32[s][t-15], 18) ^ (m32[s][t-15] >> 3))
                     + m32[s][t-16];
  endtask

  task automatic sched64(input logic [1023:0] b);
    for (int t = 0; t < 80; t++)
      if (t < 16) m64[t] = b[1023-64*t -: 64];
      else m64[t] = (rr64(m64[t-2], 19) ^ rr64(m64[t-2], 61) ^ (m64[t-2] >> 6))
                  + m64[t-7]
                  + (rr64(m64[t-15], 1) ^ rr64(m64[t-15], 8) ^ (m64[t-15] >> 7))
                  + m64[t-16];
  endtask

  task automatic start32(input logic [511:0] b);
    bv32 = 1'b1;
    blk32 = b;
    chk("accept_ready", 64'(br32), 64'(1));
    step;
    bv32 = 1'b0;
    blk32 = ~b;
  endtask

  task automatic drain32(input int s, input int from, input bit stall);
    int idx;
    idx = from;
    for (int c = 0; c < 1000 && idx < 64; c++) begin
      wr32 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("wt_v", 64'(wv32), 64'(1));
      chk("t", 64'(t32), 64'(idx));
      chk("wt", 64'(wt32), 64'(m32[s][idx]));
      chk("last", 64'(last32), 64'(idx == 63));
      if (s == 0 && idx == 16) chk("abc_w16", 64'(wt32), 64'h61626380);
      if (s == 0 && idx == 17) chk("abc_w17", 64'(wt32), 64'h000f0000);
      step;
      if (wr32) idx++;
    end
    chk("drain_done", 64'(idx), 64'(64));
    chk("wt_v_drop", 64'(wv32), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    abc32 = '0;
    abc32[511:480] = 32'h61626380;
    abc32[31:0] = 32'h18;
    for (int k = 0; k < 16; k++) rnd32[k*32 +: 32] = $urandom();
    abc64 = '0;
    abc64[1023:960] = 64'h6162638000000000;
    abc64[63:0] = 64'h18;
    sched32(abc32, 0);
    sched32(rnd32, 1);
    sched64(abc64);
    step;
    step;
    rst = 1'b0;
    chk("rst_wt", 64'(wt32), 64'(0));
    chk("rst_t", 64'(t32), 64'(0));
    chk("rst_last", 64'(last32), 64'(0));
    chk("rst_wv", 64'(wv32), 64'(0));
    chk("rst_ready", 64'(br32), 64'(1));
    chk("rst_wv64", 64'(wv64), 64'(0));
    chk("rst_ready64", 64'(br64), 64'(1));
    start32(abc32);
    drain32(0, 0, 1'b0);
    start32(abc32);
    drain32(0, 0, 1'b1);
    wr32 = 1'b1;
    bv32 = 1'b1;
    blk32 = abc32;
    step;
    blk32 = rnd32;
    for (int i = 0; i < 128; i++) begin
      bv32 = i < 64;
      chk("b2b_wv", 64'(wv32), 64'(1));
      chk("b2b_t", 64'(t32), 64'(i % 64));
      chk("b2b_wt", 64'(wt32), 64'(m32[i/64][i%64]));
      chk("b2b_ready", 64'(br32), 64'(i % 64 == 63));
      step;
    end
    bv32 = 1'b0;
    chk("b2b_end", 64'(wv32), 64'(0));
    start32(abc32);
    wr32 = 1'b1;
    repeat (20) step;
    chk("fl_t20", 64'(t32), 64'(20));
    fl32 = 1'b1;
    chk("fl_ready", 64'(br32), 64'(0));
    step;
    chk("fl_wv", 64'(wv32), 64'(0));
    chk("fl_t", 64'(t32), 64'(0));
    bv32 = 1'b1;
    blk32 = rnd32;
    step;
    chk("fl_idle_noacc", 64'(wv32), 64'(0));
    fl32 = 1'b0;
    step;
    bv32 = 1'b0;
    drain32(1, 0, 1'b0);
    start32(abc32);
    wr32 = 1'b1;
    repeat (30) step;
    chk("rs_t30", 64'(t32), 64'(30));
    #3 rst = 1'b1;
    #1;
    chk("rs_wt", 64'(wt32), 64'(0));
    chk("rs_t", 64'(t32), 64'(0));
    chk("rs_wv", 64'(wv32), 64'(0));
    chk("rs_last", 64'(last32), 64'(0));
    chk("rs_ready", 64'(br32), 64'(1));
    step;
    rst = 1'b0;
    start32(rnd32);
    drain32(1, 0, 1'b0);
    bv64 = 1'b1;
    blk64 = abc64;
    wr64 = 1'b1;
    chk("s512_ready", 64'(br64), 64'(1));
    step;
    bv64 = 1'b0;
    blk64 = '0;
    for (int i = 0; i < 80; i++) begin
      chk("s512_wv", 64'(wv64), 64'(1));
      chk("s512_t", 64'(t64), 64'(i));
      chk("s512_wt", wt64, m64[i]);
      chk("s512_last", 64'(last64), 64'(i == 79));
      if (i == 16) chk("s512_w16", wt64, 64'h6162638000000000);
      if (i == 17) chk("s512_w17", wt64, 64'h00030000000000c0);
      step;
    end
    chk("s512_end", 64'(wv64), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
